fnd_scan_controller: RTL and testbench

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

---
 rtl/fnd_pkg.sv | 41 ++++
 rtl/bin2bcd_seq.sv | 76 +++++++
 rtl/fnd_scan_controller.sv | 150 +++++++++++++++
 tb/tb_fnd_scan_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and types for the four-digit FND scan controller.
//   NUM_DIGITS   : number of multiplexed display digits
//   BCD_BLANK    : digit code that the downstream decoder renders as an unlit digit
//   BCD_DOT      : decimal-point code; never driven onto o_bcd
//   MAX_VALUE    : largest value that can be shown in decimal
//   SEL_DIGn     : active-low digit-select patterns, digit 0 = ones
//   fsm_state_e  : conversion FSM states
package fnd_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned VALUE_W    = 14;
    localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
    localparam int unsigned MAX_VALUE  = 9999;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_DOT   = 4'hA;

    localparam logic [3:0] SEL_DIG0 = 4'b1110;
    localparam logic [3:0] SEL_DIG1 = 4'b1101;
    localparam logic [3:0] SEL_DIG2 = 4'b1011;
    localparam logic [3:0] SEL_DIG3 = 4'b0111;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StConvert = 2'd1,
        StCommit  = 2'd2
    } fsm_state_e;

    // Active-low select pattern for a digit index.
    function automatic logic [3:0] digit_sel(input logic [1:0] idx);
        logic [3:0] sel;
        unique case (idx)
            2'd0:    sel = SEL_DIG0;
            2'd1:    sel = SEL_DIG1;
            2'd2:    sel = SEL_DIG2;
            default: sel = SEL_DIG3;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 16-bit BCD converter (shift-add-3 / double dabble).
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset; abandons any conversion in flight
//   start_i : one-cycle strobe, captures bin_i and clears the BCD accumulator
//   bin_i   : binary input value
//   done_o  : high in the cycle whose rising edge performs the final shift
//   bcd_o   : BCD accumulator; holds the complete result from the edge after done_o
// A conversion takes exactly VALUE_W shift edges after the start edge. Inputs above
// 9999 produce a truncated fifth digit; the caller is expected to discard those.
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [VALUE_W-1:0] bin_i,
    output logic               done_o,
    output logic [BCD_W-1:0]   bcd_o
);

    localparam logic [3:0] LAST_STEP = 4'(VALUE_W - 1);

    logic [VALUE_W-1:0] sr_q, sr_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               run_q, run_d;
    logic [BCD_W-1:0]   adj;

    // Add 3 to every nibble that is 5 or more before the shift.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        sr_d  = sr_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            sr_d  = bin_i;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            bcd_d = {adj[BCD_W-2:0], sr_q[VALUE_W-1]};
            sr_d  = {sr_q[VALUE_W-2:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_STEP) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done_o = run_q && (cnt_q == LAST_STEP) && !start_i;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed FND controller: converts a loaded binary value to decimal
// and scans the digits out one at a time at SCAN_HZ.
//   i_clk       : clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_value     : binary value to display, 0..9999 (larger values blank the display)
//   i_load      : one-cycle strobe, accepted only while idle
//   o_busy      : high while a conversion is in flight (15 cycles per load)
//   o_overflow  : last accepted value was above 9999
//   o_bcd       : digit code for the currently selected digit (registered)
//   o_digit_sel : active-low digit enable, bit 0 = ones (registered)
// Build option: define FND_LEAD_ZERO_BLANK_EN to blank leading zero digits.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned SCAN_HZ = 1000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [VALUE_W-1:0] i_value,
    input  logic               i_load,
    output logic               o_busy,
    output logic               o_overflow,
    output logic [3:0]         o_bcd,
    output logic [3:0]         o_digit_sel
);

    localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
    localparam int unsigned PRE_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

`ifdef FND_LEAD_ZERO_BLANK_EN
    localparam logic [NUM_DIGITS-1:0][3:0] DISP_RST = {BCD_BLANK, BCD_BLANK, BCD_BLANK, 4'h0};
`else
    localparam logic [NUM_DIGITS-1:0][3:0] DISP_RST = '0;
`endif

    fsm_state_e state_q, state_d;
    logic       ovf_pend_q, ovf_pend_d;
    logic       ovf_q, ovf_d;
    logic [NUM_DIGITS-1:0][3:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0][3:0] commit_digits;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] bcd_q, bcd_d;

    logic             start;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic             tick;
    logic [1:0]       idx_next;

    assign start = (state_q == StIdle) && i_load;

    bin2bcd_seq u_bin2bcd (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .start_i (start),
        .bin_i   (i_value),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Conversion FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (i_load) state_d = StConvert;
            StConvert: if (conv_done) state_d = StCommit;
            StCommit:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Digits to be stored at COMMIT: blank everything on overflow, otherwise the
    // converted decimal digits (optionally with leading zeros blanked).
    always_comb begin
        commit_digits = conv_bcd;
        if (ovf_pend_q) begin
            commit_digits = {NUM_DIGITS{BCD_BLANK}};
        end else begin
`ifdef FND_LEAD_ZERO_BLANK_EN
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                if (conv_bcd[4*i +: 4] == 4'h0 &&
                    (i == NUM_DIGITS - 1 || commit_digits[i+1] == BCD_BLANK)) begin
                    commit_digits[i] = BCD_BLANK;
                end
            end
`endif
        end
    end

    always_comb begin
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        if (start) begin
            ovf_pend_d = (32'(i_value) > MAX_VALUE);
        end
        if (state_q == StCommit) begin
            disp_d = commit_digits;
            ovf_d  = ovf_pend_q;
        end
    end

    // Scan: the tick edge reads disp_q before any same-edge commit lands.
    assign tick     = (pre_q == PRE_LAST);
    assign idx_next = idx_q + 2'd1;

    always_comb begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        idx_d = idx_q;
        sel_d = sel_q;
        bcd_d = bcd_q;
        if (tick) begin
            idx_d = idx_next;
            sel_d = digit_sel(idx_next);
            bcd_d = (disp_q[idx_next] == BCD_DOT) ? BCD_BLANK : disp_q[idx_next];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= DISP_RST;
            pre_q      <= '0;
            idx_q      <= 2'd0;
            sel_q      <= SEL_DIG0;
            bcd_q      <= 4'h0;
        end else begin
            state_q    <= state_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            bcd_q      <= bcd_d;
        end
    end

    assign o_busy      = (state_q != StIdle);
    assign o_overflow  = ovf_q;
    assign o_bcd       = bcd_q;
    assign o_digit_sel = sel_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller (CLK_HZ=1000, SCAN_HZ=100: one tick
// every 10 clocks). A cycle-level reference model derived from edge counts and
// decimal arithmetic predicts every output; checks run on the falling edge.
module tb_fnd_scan_controller;

    logic        i_clk;
    logic        i_rst_n;
    logic [13:0] i_value;
    logic        i_load;
    logic        o_busy;
    logic        o_overflow;
    logic [3:0]  o_bcd;
    logic [3:0]  o_digit_sel;

    int n_checks = 0;
    int n_err    = 0;

    fnd_scan_controller #(
        .CLK_HZ  (1000),
        .SCAN_HZ (100)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_value     (i_value),
        .i_load      (i_load),
        .o_busy      (o_busy),
        .o_overflow  (o_overflow),
        .o_bcd       (o_bcd),
        .o_digit_sel (o_digit_sel)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    int         n;          // rising edges since reset release
    int         commit_at;  // edge number of the pending commit, -1 if idle
    int         m_val;
    logic [3:0] m_disp [4];
    logic [3:0] m_bcd;
    logic [3:0] m_sel;
    logic       m_ovf;
    logic       m_busy;

    function automatic void model_reset_digits();
        m_disp[0] = 4'h0;
        for (int i = 1; i < 4; i++) begin
`ifdef FND_LEAD_ZERO_BLANK_EN
            m_disp[i] = 4'hF;
`else
            m_disp[i] = 4'h0;
`endif
        end
    endfunction

    function automatic void model_commit(input int v);
        int div;
        bit lead;
        if (v > 9999) begin
            for (int i = 0; i < 4; i++) m_disp[i] = 4'hF;
            m_ovf = 1'b1;
        end else begin
            div = 1;
            for (int i = 0; i < 4; i++) begin
                m_disp[i] = 4'((v / div) % 10);
                div = div * 10;
            end
`ifdef FND_LEAD_ZERO_BLANK_EN
            lead = 1'b1;
            for (int i = 3; i > 0; i--) begin
                if (lead && m_disp[i] == 4'h0) m_disp[i] = 4'hF;
                else lead = 1'b0;
            end
`else
            lead = 1'b0;
`endif
            m_ovf = lead & 1'b0;
        end
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            n         = 0;
            commit_at = -1;
            m_ovf     = 1'b0;
            m_bcd     = 4'h0;
            m_sel     = 4'b1110;
            model_reset_digits();
        end else begin
            n++;
            if (n % 10 == 0) begin
                int         idx;
                logic [3:0] one;
                idx   = (n / 10) % 4;
                one   = 4'b0001;
                m_sel = ~(one << idx);
                m_bcd = m_disp[idx];
            end
            if (i_load && commit_at < 0) begin
                commit_at = n + 15;
                m_val     = int'(i_value);
            end else if (commit_at == n) begin
                model_commit(m_val);
                commit_at = -1;
            end
        end
        m_busy = (commit_at >= 0);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag);
        n_checks++;
        assert (o_busy === m_busy) else begin
            n_err++;
            $error("FAIL %s busy: got %0b expected %0b", tag, o_busy, m_busy);
        end
        n_checks++;
        assert (o_overflow === m_ovf) else begin
            n_err++;
            $error("FAIL %s overflow: got %0b expected %0b", tag, o_overflow, m_ovf);
        end
        n_checks++;
        assert (o_digit_sel === m_sel) else begin
            n_err++;
            $error("FAIL %s digit_sel: got %b expected %b", tag, o_digit_sel, m_sel);
        end
        n_checks++;
        assert (o_bcd === m_bcd) else begin
            n_err++;
            $error("FAIL %s bcd: got %h expected %h", tag, o_bcd, m_bcd);
        end
        n_checks++;
        assert (o_bcd !== 4'hA) else begin
            n_err++;
            $error("FAIL %s bcd_dot: got %h expected not a", tag, o_bcd);
        end
    endtask

    task automatic step(input int cycles, input string tag);
        repeat (cycles) begin
            @(negedge i_clk);
            check(tag);
        end
    endtask

    // Pulse i_load for one cycle at value v.
    task automatic load(input int v, input string tag);
        i_value = 14'(v);
        i_load  = 1'b1;
        @(negedge i_clk);
        i_load  = 1'b0;
        check(tag);
    endtask

    // Load v from idle and measure how many sampled cycles o_busy stays high.
    task automatic load_measure(input int v, input string tag);
        int busy_cycles;
        busy_cycles = 0;
        i_value = 14'(v);
        i_load  = 1'b1;
        @(negedge i_clk);
        i_load  = 1'b0;
        check(tag);
        for (int i = 0; i < 40 && o_busy; i++) begin
            busy_cycles++;
            @(negedge i_clk);
            check(tag);
        end
        n_checks++;
        assert (busy_cycles === 15) else begin
            n_err++;
            $error("FAIL %s busy_len: got %0d expected 15", tag, busy_cycles);
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_load  = 1'b0;
        i_value = '0;
        repeat (3) @(negedge i_clk);
        check("reset");
        i_rst_n = 1'b1;

        // Idle scan: all four digits cycle with reset contents.
        step(45, "idle_scan");

        load_measure(1234, "v1234");
        step(45, "v1234_scan");

        load_measure(10000, "v10000");
        step(45, "ovf_scan");
        n_checks++;
        assert (o_overflow === 1'b1) else begin
            n_err++;
            $error("FAIL ovf_set: got %0b expected 1", o_overflow);
        end
        load_measure(9999, "v9999");
        step(45, "v9999_scan");
        n_checks++;
        assert (o_overflow === 1'b0) else begin
            n_err++;
            $error("FAIL ovf_clr: got %0b expected 0", o_overflow);
        end

        // Second load while busy is ignored.
        load(42, "v42");
        step(4, "v42_busy");
        load(7, "v7_ignored");
        step(55, "v42_scan");

        // Randomized loads with random spacing, including overflow values.
        for (int r = 0; r < 10; r++) begin
            int v;
            v = (r % 3 == 2) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
            load(v, "rand_load");
            if ($urandom_range(0, 1) == 1) load(int'($urandom_range(0, 16383)), "rand_extra");
            step(int'($urandom_range(14, 50)), "rand_scan");
        end

        load_measure(7, "v7");
        step(45, "v7_scan");
        load_measure(0, "v0");
        step(45, "v0_scan");

        // Reset at cycle 8 of converting 5555: nothing from it may ever appear.
        load(5555, "v5555");
        step(7, "v5555_conv");
        i_rst_n = 1'b0;
        #1;
        check("mid_reset");
        @(negedge i_clk);
        check("mid_reset_hold");
        i_rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge i_clk);
            check("post_reset");
            n_checks++;
            assert (o_bcd !== 4'h5) else begin
                n_err++;
                $error("FAIL no_five: got %h expected not 5", o_bcd);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
